// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared constants for the pipeline control path: ALU op encodings, the
//   memory arbiter FSM state encodings and the owner encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // ALU operation encodings used by the execute stage.
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_t;

    // Default bus geometry: word address is byte address [31:2].
    localparam int ADDR_W_DEF = 30;
    localparam int DATA_W_DEF = 32;

    // Memory arbiter FSM state encodings.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Transaction owner encoding.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the fetch port, the load/store port and the RAM port of the
//   memory arbiter.
//   Modports:
//     slave  - the arbiter: takes i_*/d_* requests and ram_q, drives acks,
//              read data, the RAM address/data/write-enable and busy.
//     master - the surroundings (pipeline requesters and RAM).
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) ();
    // fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    // load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    // RAM port
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    // status
    logic              busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
        output i_ack, i_rdata, d_ack, d_rdata, ram_addr, ram_wdata, ram_wren, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_q,
        input  i_ack, i_rdata, d_ack, d_rdata, ram_addr, ram_wdata, ram_wren, busy
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
//   Combinational winner select for the memory arbiter.
//   Ports:
//     i_req     in   fetch request
//     d_req     in   data request
//     prio_d    in   1 = D wins a conflict, 0 = I wins a conflict
//     grant_any out  at least one request present
//     winner    out  OWN_D / OWN_I
// ---------------------------------------------------------------------------
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic prio_d,
    output logic grant_any,
    output logic winner
);

    assign grant_any = i_req | d_req;

    // A lone requester always wins; the priority bit only breaks ties.
    assign winner = (d_req && (!i_req || prio_d)) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port synchronous RAM between the fetch requester
//   (read-only) and the load/store requester. Each access runs
//   IDLE -> ACCESS -> DONE, so a request seen in cycle N is acked in N+2.
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset
//     bus      mem_arbiter_if.slave: i_* fetch port, d_* load/store port,
//              ram_* RAM port, busy
//   Configuration:
//     MEM_ARB_RR_EN  defined   : round-robin between I and D on conflict
//                    undefined : fixed D-over-I priority
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);

    logic [1:0]        state_reg;
    logic              owner_reg;
    logic              store_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              ram_wren_reg;
    logic              i_ack_reg;
    logic              d_ack_reg;
    logic [DATA_W-1:0] i_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    logic              prio_d;
    logic              grant_any;
    logic              winner;

    mem_arb_pick u_pick (
        .i_req     (bus.i_req),
        .d_req     (bus.d_req),
        .prio_d    (prio_d),
        .grant_any (grant_any),
        .winner    (winner)
    );

`ifdef MEM_ARB_RR_EN
    // Points at the port that was not served last; starts out favouring D.
    logic prio_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_reg <= 1'b1;
        end else if (state_reg == ST_IDLE && grant_any) begin
            prio_reg <= (winner == OWN_I);
        end
    end

    assign prio_d = prio_reg;
`else
    // Fixed priority: the pipeline stalls fetch during a memory stage, so
    // letting D starve I is intended.
    assign prio_d = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            owner_reg     <= OWN_I;
            store_reg     <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_wren_reg  <= 1'b0;
            i_ack_reg     <= 1'b0;
            d_ack_reg     <= 1'b0;
            i_rdata_reg   <= '0;
            d_rdata_reg   <= '0;
        end else begin
            i_ack_reg <= 1'b0;
            d_ack_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        state_reg     <= ST_ACCESS;
                        owner_reg     <= winner;
                        store_reg     <= (winner == OWN_D) && bus.d_we;
                        ram_addr_reg  <= (winner == OWN_D) ? bus.d_addr : bus.i_addr;
                        ram_wdata_reg <= (winner == OWN_D) ? bus.d_wdata : '0;
                        ram_wren_reg  <= (winner == OWN_D) && bus.d_we;
                    end
                end
                ST_ACCESS: begin
                    // The RAM samples address/wren on the edge that ends this cycle.
                    state_reg    <= ST_DONE;
                    ram_wren_reg <= 1'b0;
                    if (owner_reg == OWN_D) begin
                        d_ack_reg <= 1'b1;
                    end else begin
                        i_ack_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    if (owner_reg == OWN_I) begin
                        i_rdata_reg <= bus.ram_q;
                    end else if (!store_reg) begin
                        d_rdata_reg <= bus.ram_q;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // ram_q first becomes valid in DONE, the same cycle as the ack, so the
    // word is forwarded during the ack and held in the register afterwards.
    assign bus.i_rdata   = i_ack_reg ? bus.ram_q : i_rdata_reg;
    assign bus.d_rdata   = (d_ack_reg && !store_reg) ? bus.ram_q : d_rdata_reg;
    assign bus.i_ack     = i_ack_reg;
    assign bus.d_ack     = d_ack_reg;
    assign bus.ram_addr  = ram_addr_reg;
    assign bus.ram_wdata = ram_wdata_reg;
    assign bus.ram_wren  = ram_wren_reg;
    assign bus.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural one-cycle-latency RAM.
//   Expected acks (data and cycle) are queued per port when a request is
//   issued; a monitor pops and compares whenever an ack appears.
//   Honours MEM_ARB_RR_EN for the arbitration-order expectations.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 30;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cycle = 0;
    int   vectors = 0;
    int   miscompares = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // ---------------- RAM model: unwritten words hold a fixed pattern ----
    logic [DW-1:0] mem [256];
    logic [255:0]  written = '0;

    function automatic logic [31:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hA5A500, a};
    endfunction

    always @(posedge clk) begin
        if (bus.ram_wren) begin
            mem[bus.ram_addr[7:0]]     <= bus.ram_wdata;
            written[bus.ram_addr[7:0]] <= 1'b1;
        end
        bus.ram_q <= written[bus.ram_addr[7:0]] ? mem[bus.ram_addr[7:0]] : pat(bus.ram_addr[7:0]);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_i[$];
    exp_t exp_d[$];

    task automatic score(input string nm, input bit is_d, input logic [31:0] got);
        exp_t e;
        vectors++;
        if ((is_d && exp_d.size() == 0) || (!is_d && exp_i.size() == 0)) begin
            miscompares++;
            $display("FAIL %s: unexpected ack at cycle %0d, rdata=%h, required no ack", nm, cycle, got);
            return;
        end
        if (is_d) e = exp_d.pop_front();
        else      e = exp_i.pop_front();
        if (got !== e.data || cycle != e.cyc) begin
            miscompares++;
            $display("FAIL %s: got rdata=%h at cycle %0d, required rdata=%h at cycle %0d",
                     nm, got, cycle, e.data, e.cyc);
        end else begin
            $display("ok   %s: rdata=%h at cycle %0d", nm, got, cycle);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.i_ack) score("i_ack", 1'b0, bus.i_rdata);
                if (bus.d_ack) score("d_ack", 1'b1, bus.d_rdata);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask

    task automatic check_idle(input string nm);
        check({nm, " acks/wren/busy"},
              {28'h0, bus.i_ack, bus.d_ack, bus.ram_wren, bus.busy}, 32'h0);
        check({nm, " ram_addr"}, {2'b00, bus.ram_addr}, 32'h0);
        check({nm, " ram_wdata"}, bus.ram_wdata, 32'h0);
        check({nm, " i_rdata"}, bus.i_rdata, 32'h0);
        check({nm, " d_rdata"}, bus.d_rdata, 32'h0);
    endtask

    // Wait until absolute cycle c (sampled at negedge), then check the RAM port.
    task automatic ram_at(input int c, input string nm, input logic [AW-1:0] a, input logic w);
        while (cycle < c) @(negedge clk);
        check({nm, " ram_addr"}, {2'b00, bus.ram_addr}, {2'b00, a});
        check({nm, " ram_wren"}, {31'h0, bus.ram_wren}, {31'h0, w});
    endtask

    // Called at a negedge: raises the request now (this is cycle 0 of the
    // transaction), queues the expected ack at cycle 0 + lat and waits for it.
    task automatic do_txn(input bit is_d, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input int lat, input bit hold);
        exp_t e;
        int   n;
        bit   seen;
        e.data = exp_data;
        e.cyc  = cycle + lat;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
            exp_d.push_back(e);
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
            exp_i.push_back(e);
        end
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = is_d ? bus.d_ack : bus.i_ack;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: no ack within 40 cycles for addr %h", is_d ? "d" : "i", addr);
        end
        if (!hold) begin
            @(negedge clk);
            if (is_d) bus.d_req = 1'b0;
            else      bus.i_req = 1'b0;
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int c;

    initial begin
        // 1: reset with both requests pending, then D goes first
        bus.i_req = 1'b1; bus.i_addr = 30'h8;
        bus.d_req = 1'b1; bus.d_addr = 30'h4; bus.d_we = 1'b0; bus.d_wdata = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("t1 reset");
        reset_n = 1'b1;
        fork
            do_txn(1'b1, 1'b0, 30'h4, 32'h0, 32'hA5A50004, 2, 1'b0);
            do_txn(1'b0, 1'b0, 30'h8, 32'h0, 32'hA5A50008, 5, 1'b0);
        join

        // 2: fetch; d_rdata must be left alone
        @(negedge clk);
        c = cycle;
        fork
            do_txn(1'b0, 1'b0, 30'h10, 32'h0, 32'hDEADBEEF, 2, 1'b0);
            ram_at(c + 1, "t2 access", 30'h10, 1'b0);
        join
        check("t2 d_rdata kept", bus.d_rdata, 32'hA5A50004);

        // 3: store then load back
        @(negedge clk);
        c = cycle;
        fork
            do_txn(1'b1, 1'b1, 30'h20, 32'h12345678, 32'hA5A50004, 2, 1'b0);
            begin
                ram_at(c + 1, "t3 store access", 30'h20, 1'b1);
                ram_at(c + 2, "t3 store done", 30'h20, 1'b0);
            end
        join
        check("t3 ram word", mem[8'h20], 32'h12345678);
        @(negedge clk);
        do_txn(1'b1, 1'b0, 30'h20, 32'h0, 32'h12345678, 2, 1'b0);

        // 4: simultaneous requests from a reset priority state
        apply_reset();
        c = cycle;
        fork
            do_txn(1'b1, 1'b0, 30'h30, 32'h0, 32'hA5A50030, 2, 1'b0);
            do_txn(1'b0, 1'b0, 30'h40, 32'h0, 32'hA5A50040, 5, 1'b0);
            begin
                ram_at(c + 1, "t4 d access", 30'h30, 1'b0);
                ram_at(c + 4, "t4 i access", 30'h40, 1'b0);
            end
        join

        // 5: reset during ACCESS aborts the load
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 30'h50;
        @(negedge clk);
        check("t5 busy in access", {31'h0, bus.busy}, 32'h1);
        reset_n = 1'b0;
        #1;
        check_idle("t5 reset");
        @(negedge clk);
        check("t5 no d_ack", {31'h0, bus.d_ack}, 32'h0);
        bus.d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_txn(1'b1, 1'b0, 30'h50, 32'h0, 32'hA5A50050, 2, 1'b0);

        // 6: both requests held across four grants
        apply_reset();
        fork
`ifdef MEM_ARB_RR_EN
            begin
                do_txn(1'b1, 1'b0, 30'h60, 32'h0, 32'hA5A50060, 2, 1'b1);
                @(negedge clk);
                do_txn(1'b1, 1'b0, 30'h64, 32'h0, 32'hA5A50064, 5, 1'b0);
            end
            begin
                do_txn(1'b0, 1'b0, 30'h70, 32'h0, 32'hA5A50070, 5, 1'b1);
                @(negedge clk);
                do_txn(1'b0, 1'b0, 30'h74, 32'h0, 32'hA5A50074, 5, 1'b0);
            end
`else
            begin
                do_txn(1'b1, 1'b0, 30'h60, 32'h0, 32'hA5A50060, 2, 1'b1);
                @(negedge clk);
                do_txn(1'b1, 1'b0, 30'h64, 32'h0, 32'hA5A50064, 2, 1'b1);
                @(negedge clk);
                do_txn(1'b1, 1'b0, 30'h68, 32'h0, 32'hA5A50068, 2, 1'b1);
                @(negedge clk);
                do_txn(1'b1, 1'b0, 30'h6C, 32'h0, 32'hA5A5006C, 2, 1'b0);
            end
            // I is starved until D lets go after its fourth grant.
            do_txn(1'b0, 1'b0, 30'h70, 32'h0, 32'hA5A50070, 14, 1'b0);
`endif
        join

        repeat (3) @(negedge clk);
        check("end pending i", exp_i.size(), 32'h0);
        check("end pending d", exp_d.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
